// File: rtl/alu_operand_driver.sv
// Initiator-side front end of the multi-cycle ALU input interface.
// Registers one request per handshake and serializes A then B, LSB byte first.
module alu_operand_driver #(
    parameter int unsigned OPERAND_BUS_WIDTH      = 8,
    parameter int unsigned OPERAND_MAX_DATA_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [2:0]                        req_op,
    input  logic [OPERAND_MAX_DATA_WIDTH-1:0] req_a,
    input  logic [OPERAND_MAX_DATA_WIDTH-1:0] req_b,
    input  logic [1:0]                        req_a_len,
    input  logic [1:0]                        req_b_len,
    output logic                              alu_in_valid,
    input  logic                              alu_in_ready,
    output logic [2:0]                        alu_in_op,
    output logic [OPERAND_BUS_WIDTH-1:0]      alu_in_data,
    output logic                              alu_in_sel,
    output logic                              alu_in_last,
    output logic                              busy,
    output logic [7:0]                        bad_op_cnt
);

    localparam int unsigned BEATS_MAX = OPERAND_MAX_DATA_WIDTH / OPERAND_BUS_WIDTH;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SEND_A   = 2'd1;
    localparam logic [1:0] SEND_B   = 2'd2;
    localparam logic [1:0] SEND_RST = 2'd3;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_RST = 3'b111;

    // Operands viewed as an array of bus-width beats so the beat counter indexes directly.
    typedef logic [BEATS_MAX-1:0][OPERAND_BUS_WIDTH-1:0] operand_t;

    logic [1:0] state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [2:0] op_q, op_d;
    operand_t   a_q, a_d;
    operand_t   b_q, b_d;
    logic [1:0] a_len_q, a_len_d;
    logic [1:0] b_len_q, b_len_d;
    logic [7:0] bad_q, bad_d;

    logic accept;
    logic beat_xfer;

    assign req_ready  = (state_q == IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign beat_xfer  = alu_in_valid && alu_in_ready;
    assign busy       = (state_q != IDLE);
    assign bad_op_cnt = bad_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        a_len_d = a_len_q;
        b_len_d = b_len_q;
        bad_d   = bad_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (req_op)
                        OP_ADD, OP_AND, OP_XOR, OP_MUL: begin
                            op_d    = req_op;
                            a_d     = req_a;
                            b_d     = req_b;
                            a_len_d = req_a_len;
                            b_len_d = req_b_len;
                            cnt_d   = 2'd0;
                            state_d = SEND_A;
                        end
                        OP_RST: begin
                            op_d    = OP_RST;
                            cnt_d   = 2'd0;
                            state_d = SEND_RST;
                        end
                        OP_NOP: ;
                        default: begin
                            if (bad_q != 8'hFF) bad_d = bad_q + 8'd1;
                        end
                    endcase
                end
            end
            SEND_A: begin
                if (beat_xfer) begin
                    if (cnt_q == a_len_q) begin
                        cnt_d   = 2'd0;
                        state_d = SEND_B;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            SEND_B: begin
                if (beat_xfer) begin
                    if (cnt_q == b_len_q) begin
                        cnt_d   = 2'd0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            SEND_RST: begin
                if (beat_xfer) begin
                    cnt_d   = 2'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat outputs decode straight from state so an async reset drops them immediately.
    always_comb begin
        alu_in_valid = (state_q != IDLE);
        alu_in_op    = alu_in_valid ? op_q : OP_NOP;
        alu_in_sel   = (state_q == SEND_B);
        alu_in_last  = (state_q == SEND_RST) || ((state_q == SEND_B) && (cnt_q == b_len_q));
        alu_in_data  = '0;
        case (state_q)
            SEND_A:  alu_in_data = a_q[cnt_q];
            SEND_B:  alu_in_data = b_q[cnt_q];
            default: alu_in_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            op_q    <= OP_NOP;
            a_q     <= '0;
            b_q     <= '0;
            a_len_q <= 2'd0;
            b_len_q <= 2'd0;
            bad_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_len_q <= a_len_d;
            b_len_q <= b_len_d;
            bad_q   <= bad_d;
        end
    end

endmodule

// File: doc/alu_operand_driver.md
Name: alu_operand_driver

Overview:
- Initiator-side front end of the multi-cycle ALU input interface.
- Accepts one complete request per handshake: opcode, operand A, operand B, and per-operand byte lengths.
- Serializes the request LSB-first onto the narrow ALU operand bus, A before B, honouring ALU backpressure.
- Used by the stimulus path and by the system-level host model.

Parameters:
- OPERAND_BUS_WIDTH, 8, width of one ALU input beat in bits.
- OPERAND_MAX_DATA_WIDTH, 32, maximum operand width in bits; must be a multiple of OPERAND_BUS_WIDTH.
- BEATS_MAX, OPERAND_MAX_DATA_WIDTH/OPERAND_BUS_WIDTH (4), maximum beats per operand. Derived; not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  driver can accept a request.
- req_op  in  3  opcode: no_op=000, add=001, and=010, xor=011, mul=100, rst=111.
- req_a  in  OPERAND_MAX_DATA_WIDTH  operand A.
- req_b  in  OPERAND_MAX_DATA_WIDTH  operand B.
- req_a_len  in  2  operand A beat count minus 1 (0..3).
- req_b_len  in  2  operand B beat count minus 1 (0..3).
- alu_in_valid  out  1  beat valid.
- alu_in_ready  in  1  ALU accepts beat.
- alu_in_op  out  3  opcode of the current request, held for all beats.
- alu_in_data  out  OPERAND_BUS_WIDTH  beat payload.
- alu_in_sel  out  1  0 = operand A beat, 1 = operand B beat.
- alu_in_last  out  1  final beat of the request.
- busy  out  1  request in progress.
- bad_op_cnt  out  8  saturating count of illegal opcodes received.

Behaviour:
- Reset values (async assert, sync release): req_ready=1 after release; alu_in_valid=0, alu_in_op=000, alu_in_data=0, alu_in_sel=0, alu_in_last=0, busy=0, bad_op_cnt=0; FSM enters IDLE.
- Reset asserted mid-request aborts the request; no further beats are driven.
- Request handshake:
  - Accepted when req_valid && req_ready.
  - req_ready=1 only in IDLE.
  - All request fields are registered at acceptance; later changes to the inputs are ignored.
- Beat handshake:
  - A beat transfers when alu_in_valid && alu_in_ready.
  - While alu_in_valid=1 and alu_in_ready=0, alu_in_data, alu_in_op, alu_in_sel and alu_in_last hold stable.
  - alu_in_valid never deasserts before the beat transfers.
- FSM states: IDLE, SEND_A, SEND_B, SEND_RST.
- IDLE transitions on accept:
  - add/and/xor/mul -> SEND_A.
  - rst -> SEND_RST.
  - no_op -> stays IDLE; no beat is driven.
  - 101/110 -> stays IDLE; bad_op_cnt increments, saturating at 255.
- Latency: request accepted at edge t drives the first beat valid during cycle t+1.
- SEND_A:
  - Drives beats k=0..req_a_len; alu_in_data = A[8k+7:8k]; alu_in_sel=0.
  - On transfer of beat req_a_len -> SEND_B.
- SEND_B:
  - Drives beats k=0..req_b_len from B; alu_in_sel=1.
  - alu_in_last=1 on beat req_b_len only.
  - On that transfer -> IDLE.
  - req_ready rises the cycle after the last transfer; there is no same-cycle back-to-back.
- SEND_RST:
  - One beat: alu_in_op=111, alu_in_data=0, alu_in_sel=0, alu_in_last=1.
  - On transfer -> IDLE.
- Back-to-back beats:
  - With alu_in_ready held at 1, one beat transfers per cycle with no bubbles inside a request.
  - A request takes (a_len+1)+(b_len+1) beat cycles.
- Beat counter: 2-bit; resets to 0 on every state entry; never wraps within a state.
- Bytes of A/B above the programmed length are never driven.
- busy = (state != IDLE).

Test Plan:
- Reset release, idle: req_ready=1, alu_in_valid=0, bad_op_cnt=0. Assert rst mid-SEND_B -> alu_in_valid=0 asynchronously, FSM IDLE.
- add, A=0x12345678, B=0xAABBCCDD, a_len=3, b_len=3, ready=1:
  - Beats 78,56,34,12 with sel=0.
  - Then DD,CC,BB,AA with sel=1; last=1 on AA only.
  - 8 consecutive cycles; first beat at t+1.
- mul, A=0x05, B=0x0102, a_len=0, b_len=1; alu_in_ready toggling 1,0,0,1,1:
  - Beats 05, 02, 01 in order.
  - Data held stable across the stalls; op=100 on every beat.
- rst_op request -> exactly one beat: op=111, data=00, last=1. Following no_op request -> no beat, req_ready stays 1.
- Opcodes 101 then 110 -> no beats, bad_op_cnt=2. 300 illegal requests -> bad_op_cnt saturates at 255.
- req_a changes after acceptance (0x11 -> 0xFF) -> driven beat still 0x11. req_valid held high -> second request accepted only after the previous last beat transfers.
